// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - FSM states, key codes and row/col-to-hex map for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_PRESSED = 2'd2,
        ST_RELEASE = 2'd3
    } scan_state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Nibble {row,col} holds the code; row3 reads * 0 # D from col0 to col3.
    localparam logic [63:0] KEY_MAP = {4'hD, KEY_HASH, 4'h0, KEY_STAR,
                                       16'hC987, 16'hB654, 16'hA321};

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for active-low inputs, resets to all-ones
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with press/release debounce, one code per press
// Option: KEYPAD_GHOST_REJECT_EN treats samples with two or more low columns as no key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 250,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_o,
    input  logic [3:0] col_i,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(DEBOUNCE_SCANS - 1);
    localparam logic [MW-1:0] MATCH_ONE   = MW'(1);
    localparam bit            SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

    logic [3:0]    col_s;
    logic [3:0]    col_low;
    logic [DW-1:0] dwell_cnt;
    logic          tick;
    logic          col_any;
    logic          key_seen;
    logic [1:0]    col_idx;

    scan_state_t   state, state_nxt;
    logic [1:0]    row_idx, row_idx_nxt;
    logic [1:0]    lock_col, lock_col_nxt;
    logic [MW-1:0] match_cnt, match_cnt_nxt;
    logic [3:0]    row_nxt;
    logic [3:0]    key_code_nxt;
    logic          key_valid_nxt;
    logic          key_held_nxt;

    sync_2ff #(
        .WIDTH (4)
    ) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col_i),
        .q     (col_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (tick) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    assign tick    = (dwell_cnt == DWELL_LAST);
    assign col_low = ~col_s;
    assign col_any = |col_low;

    always_comb begin
        col_idx = 2'd3;
        if (col_low[0]) begin
            col_idx = 2'd0;
        end else if (col_low[1]) begin
            col_idx = 2'd1;
        end else if (col_low[2]) begin
            col_idx = 2'd2;
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic col_multi;
    // Clearing the lowest set bit leaves something only when two or more columns are low.
    assign col_multi = |(col_low & (col_low - 4'd1));
    assign key_seen  = col_any && !col_multi;
`else
    assign key_seen  = col_any;
`endif

    always_comb begin
        state_nxt     = state;
        row_idx_nxt   = row_idx;
        lock_col_nxt  = lock_col;
        match_cnt_nxt = match_cnt;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;

        case (state)
            ST_SCAN: begin
                if (tick) begin
                    if (key_seen) begin
                        lock_col_nxt = col_idx;
                        if (SINGLE_SCAN) begin
                            state_nxt     = ST_PRESSED;
                            key_code_nxt  = key_lookup(row_idx, col_idx);
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            match_cnt_nxt = '0;
                        end else begin
                            state_nxt     = ST_CONFIRM;
                            match_cnt_nxt = MATCH_ONE;
                        end
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
            end

            ST_CONFIRM: begin
                if (tick) begin
                    if (key_seen && (col_idx == lock_col)) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt     = ST_PRESSED;
                            key_code_nxt  = key_lookup(row_idx, lock_col);
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            match_cnt_nxt = '0;
                        end else begin
                            match_cnt_nxt = match_cnt + MATCH_ONE;
                        end
                    end else begin
                        state_nxt     = ST_SCAN;
                        row_idx_nxt   = row_idx + 2'd1;
                        match_cnt_nxt = '0;
                    end
                end
            end

            // Only the locked row is driven here, so keys in other rows never reach col_s.
            ST_PRESSED: begin
                if (tick && !col_any) begin
                    if (SINGLE_SCAN) begin
                        state_nxt     = ST_SCAN;
                        row_idx_nxt   = row_idx + 2'd1;
                        key_held_nxt  = 1'b0;
                        match_cnt_nxt = '0;
                    end else begin
                        state_nxt     = ST_RELEASE;
                        match_cnt_nxt = MATCH_ONE;
                    end
                end
            end

            ST_RELEASE: begin
                if (tick) begin
                    if (col_any) begin
                        state_nxt     = ST_PRESSED;
                        match_cnt_nxt = '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state_nxt     = ST_SCAN;
                        row_idx_nxt   = row_idx + 2'd1;
                        key_held_nxt  = 1'b0;
                        match_cnt_nxt = '0;
                    end else begin
                        match_cnt_nxt = match_cnt + MATCH_ONE;
                    end
                end
            end

            default: begin
                state_nxt     = ST_SCAN;
                match_cnt_nxt = '0;
            end
        endcase

        row_nxt = ~(4'b0001 << row_idx_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            row_o     <= 4'b1110;
            lock_col  <= 2'd0;
            match_cnt <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            row_o     <= row_nxt;
            lock_col  <= lock_col_nxt;
            match_cnt <= match_cnt_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed table-driven bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 4;
    localparam int MAX_LAT  = 2 + 4 * SCAN_DIV + DEB * SCAN_DIV + 1;

    typedef struct {
        int         idx;
        logic [3:0] code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_o;
    logic [3:0]  col_i;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int          checks = 0;
    int          failures = 0;
    int          valid_count = 0;
    int          double_pulse = 0;
    logic        prev_valid = 1'b0;
    logic [3:0]  last_code = 4'h0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_o     (row_o),
        .col_i     (col_i),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Passive matrix: a pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_o[r] && pressed[r*4+c]) begin
                    col_i[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) begin
            valid_count++;
            last_code = key_code;
            if (prev_valid) begin
                double_pulse++;
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            if (key_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_held_low(input int budget, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            if (!key_held) seen = 1'b1;
        end
    endtask

    task automatic wait_row(input logic [3:0] row, input int budget, output bit seen);
        int n;
        n = 0;
        while (row_o !== row && n < budget) begin
            @(negedge clk);
            n++;
        end
        seen = (row_o === row);
    endtask

    vec_t vecs[16];
    int   lat;
    bit   seen;
    int   c0;
    int   n;
    bit   held_dropped;

    initial begin
        vecs[0]  = '{0,  4'h1}; vecs[1]  = '{1,  4'h2}; vecs[2]  = '{2,  4'h3}; vecs[3]  = '{3,  4'hA};
        vecs[4]  = '{4,  4'h4}; vecs[5]  = '{5,  4'h5}; vecs[6]  = '{6,  4'h6}; vecs[7]  = '{7,  4'hB};
        vecs[8]  = '{8,  4'h7}; vecs[9]  = '{9,  4'h8}; vecs[10] = '{10, 4'h9}; vecs[11] = '{11, 4'hC};
        vecs[12] = '{12, 4'hE}; vecs[13] = '{13, 4'h0}; vecs[14] = '{14, 4'hF}; vecs[15] = '{15, 4'hD};

        cycles(3);
        check("reset_row", row_o, 4'b1110);
        check("reset_code", key_code, 4'h0);
        check("reset_valid", key_valid, 1'b0);
        check("reset_held", key_held, 1'b0);
        rst_n = 1'b1;

        wait_row(4'b1101, 64, seen);
        check("rot_reach_row1", seen, 1'b1);
        n = 0;
        while (row_o === 4'b1101 && n < 64) begin @(negedge clk); n++; end
        check("rot_dwell", n, SCAN_DIV);
        check("rot_next_row", row_o, 4'b1011);
        while (row_o !== 4'b1101 && n < 128) begin @(negedge clk); n++; end
        check("rot_period", n, 4 * SCAN_DIV);

        for (int i = 0; i < 16; i++) begin
            c0 = valid_count;
            pressed[vecs[i].idx] = 1'b1;
            wait_valid(MAX_LAT + 4, lat, seen);
            check($sformatf("tbl%0d_seen", i), seen, 1'b1);
            check($sformatf("tbl%0d_lat_ok", i), (lat >= 3 * SCAN_DIV + 3 && lat <= MAX_LAT), 1'b1);
            check($sformatf("tbl%0d_code", i), key_code, vecs[i].code);
            check($sformatf("tbl%0d_held", i), key_held, 1'b1);
            cycles(60);
            check($sformatf("tbl%0d_one_pulse", i), valid_count, c0 + 1);
            pressed[vecs[i].idx] = 1'b0;
            wait_held_low(60, lat, seen);
            check($sformatf("tbl%0d_rel_lat_ok", i), (seen && lat >= 26 && lat <= 35), 1'b1);
        end

        // Bounce on row3/col0: toggles every 5 cycles never gives 4 consecutive matching ticks.
        c0 = valid_count;
        for (int i = 0; i < 8; i++) begin
            pressed[12] = ~pressed[12];
            cycles(5);
        end
        check("bounce_no_valid", valid_count, c0);
        pressed[12] = 1'b1;
        wait_valid(MAX_LAT + 4, lat, seen);
        check("bounce_seen", seen, 1'b1);
        check("bounce_code", key_code, 4'hE);
        cycles(40);
        check("bounce_one_pulse", valid_count, c0 + 1);
        pressed[12] = 1'b0;
        wait_held_low(60, lat, seen);
        check("bounce_released", seen, 1'b1);

        // Release glitch spanning two ticks while 6 is held.
        pressed[6] = 1'b1;
        wait_valid(MAX_LAT + 4, lat, seen);
        check("glitch_code", key_code, 4'h6);
        c0 = valid_count;
        cycles(10);
        held_dropped = 1'b0;
        pressed[6] = 1'b0;
        for (int i = 0; i < 2 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (!key_held) held_dropped = 1'b1;
        end
        pressed[6] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!key_held) held_dropped = 1'b1;
        end
        check("glitch_held_stays", held_dropped, 1'b0);
        check("glitch_no_repeat", valid_count, c0);
        pressed[6] = 1'b0;
        wait_held_low(60, lat, seen);
        check("glitch_final_release", seen, 1'b1);
        check("glitch_no_valid_on_release", valid_count, c0);

        // Second key in another row while 5 is locked stays invisible.
        pressed[5] = 1'b1;
        wait_valid(MAX_LAT + 4, lat, seen);
        check("two_first_code", key_code, 4'h5);
        c0 = valid_count;
        pressed[10] = 1'b1;
        cycles(150);
        check("two_no_second", valid_count, c0);
        check("two_code_kept", key_code, 4'h5);
        pressed[5]  = 1'b0;
        pressed[10] = 1'b0;
        wait_held_low(60, lat, seen);
        check("two_released", seen, 1'b1);
        pressed[10] = 1'b1;
        wait_valid(MAX_LAT + 4, lat, seen);
        check("two_fresh_seen", seen, 1'b1);
        check("two_fresh_code", key_code, 4'h9);
        pressed[10] = 1'b0;
        wait_held_low(60, lat, seen);
        check("two_fresh_released", seen, 1'b1);

        // Reset asserted while the scanner is confirming key 1 on row0.
        wait_row(4'b1101, 64, seen);
        pressed[0] = 1'b1;
        wait_row(4'b1110, 64, seen);
        check("rst_row0_reached", seen, 1'b1);
        cycles(SCAN_DIV + 7);
        c0 = valid_count;
        rst_n = 1'b0;
        #1;
        check("rst_mid_row", row_o, 4'b1110);
        check("rst_mid_code", key_code, 4'h0);
        check("rst_mid_valid", key_valid, 1'b0);
        check("rst_mid_held", key_held, 1'b0);
        pressed[0] = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(100);
        check("rst_no_valid", valid_count, c0);

        // Two low columns on row0 (keys 2 and A).
        c0 = valid_count;
        pressed[1] = 1'b1;
        pressed[3] = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
        cycles(150);
        check("ghost_rejected", valid_count, c0);
`else
        wait_valid(MAX_LAT + 4, lat, seen);
        check("ghost_lowest_seen", seen, 1'b1);
        check("ghost_lowest_code", key_code, 4'h2);
`endif
        pressed[1] = 1'b0;
        pressed[3] = 1'b0;
        cycles(60);

        check("valid_single_cycle", double_pulse, 0);
        check("last_code_seen", last_code, key_code);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
